reg_file_2r1w: RTL and testbench

Parametrised register file with one byte-strobed write port and two independent registered read ports, used as the operand/configuration store between the UART-side control FSM and the ALU. Successor to the single-port register file: adds separate read and write addresses, a second read port, per-byte write strobes, same-cycle write-through forwarding, read-valid flags, and non-zero reset values for the configuration lines. Lines 0–3 are also tapped out continuously, for ALU operands A and B, the UART configuration and the prescale.

---
 rtl/reg_file_2r1w.sv | 93 +++++++++
 tb/tb_reg_file_2r1w.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_2r1w.sv
// Two-read / one-write register file with byte strobes, write-through forwarding
// on both read ports, and continuous taps of lines 0-3 for the ALU and UART.
module reg_file_2r1w #(
  parameter int              WIDTH    = 16,
  parameter int              LINES    = 8,
  parameter logic [31:0]     CFG2_RST = 32'h0081,
  parameter logic [31:0]     CFG3_RST = 32'h0020,
  localparam int             AW       = $clog2(LINES),
  localparam int             SW       = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [SW-1:0]    wr_strb,
  input  logic             rd_en_a,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  output logic             rd_valid_a,
  input  logic             rd_en_b,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_valid_b,
  output logic [WIDTH-1:0] reg0,
  output logic [WIDTH-1:0] reg1,
  output logic [WIDTH-1:0] reg2,
  output logic [WIDTH-1:0] reg3
);

  if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
    $error("reg_file_2r1w: WIDTH must be a multiple of 8, minimum 8");
  end
  if (LINES < 4 || (LINES & (LINES - 1)) != 0) begin : g_bad_lines
    $error("reg_file_2r1w: LINES must be a power of 2, minimum 4");
  end

  localparam logic [WIDTH-1:0] LINE2_RST = WIDTH'(CFG2_RST);
  localparam logic [WIDTH-1:0] LINE3_RST = WIDTH'(CFG3_RST);

  logic [WIDTH-1:0] mem [LINES];
  logic [WIDTH-1:0] wr_merged;
  logic [WIDTH-1:0] fwd_a, fwd_b;

  // The merged line is both the value stored and the value forwarded, so a
  // same-edge read can never see pre-write data.
  always_comb begin
    // NOTE: default assignment first so no path through the loop leaves
    // wr_merged unassigned and infers a latch.
    wr_merged = mem[wr_addr];
    for (int k = 0; k < SW; k++) begin
      if (wr_strb[k]) wr_merged[8*k +: 8] = wr_data[8*k +: 8];
    end
  end

  assign fwd_a = (wr_en && (wr_addr == rd_addr_a)) ? wr_merged : mem[rd_addr_a];
  assign fwd_b = (wr_en && (wr_addr == rd_addr_b)) ? wr_merged : mem[rd_addr_b];

  // NOTE: the storage is reset because lines 2 and 3 carry live configuration
  // values; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LINES; i++) begin
        // NOTE: non-blocking for all sequential state so readers in other
        // always_ff blocks see the pre-edge value.
        mem[i] <= (i == 2) ? LINE2_RST : (i == 3) ? LINE3_RST : '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_merged;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_a  <= '0;
      rd_valid_a <= 1'b0;
      rd_data_b  <= '0;
      rd_valid_b <= 1'b0;
    end else begin
      rd_valid_a <= rd_en_a;
      rd_valid_b <= rd_en_b;
      if (rd_en_a) rd_data_a <= fwd_a;
      if (rd_en_b) rd_data_b <= fwd_b;
    end
  end

  // Taps come straight from storage: no forwarding, one edge behind a write.
  assign reg0 = mem[0];
  assign reg1 = mem[1];
  assign reg2 = mem[2];
  assign reg3 = mem[3];

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench for reg_file_2r1w: expected read data queued at issue,
// popped and compared one edge later; taps compared against a line model.
module tb_reg_file_2r1w;
  localparam int W  = 16;
  localparam int L  = 8;
  localparam int AW = 3;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [SW-1:0] wr_strb;
  logic          rd_en_a, rd_en_b;
  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic [W-1:0]  rd_data_a, rd_data_b;
  logic          rd_valid_a, rd_valid_b;
  logic [W-1:0]  reg0, reg1, reg2, reg3;

  reg_file_2r1w dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b),
    .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] model [L];
  logic [W-1:0] qa [$];
  logic [W-1:0] qb [$];
  logic [W-1:0] last_a, last_b;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] merge(input logic [W-1:0] old_v,
                                         input logic [W-1:0] data,
                                         input logic [SW-1:0] strb);
    logic [W-1:0] r;
    r = old_v;
    for (int k = 0; k < SW; k++) if (strb[k]) r[8*k +: 8] = data[8*k +: 8];
    return r;
  endfunction

  function automatic logic [W-1:0] expect_rd(input logic [AW-1:0] a);
    if (wr_en && wr_addr == a) return merge(model[a], wr_data, wr_strb);
    return model[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < L; i++) model[i] = '0;
    model[2] = 16'h0081;
    model[3] = 16'h0020;
    last_a = '0;
    last_b = '0;
    qa.delete();
    qb.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_va"}, {15'b0, rd_valid_a}, 16'h0);
    check({tag, "_vb"}, {15'b0, rd_valid_b}, 16'h0);
    check({tag, "_da"}, rd_data_a, 16'h0);
    check({tag, "_db"}, rd_data_b, 16'h0);
    check({tag, "_reg0"}, reg0, 16'h0000);
    check({tag, "_reg1"}, reg1, 16'h0000);
    check({tag, "_reg2"}, reg2, 16'h0081);
    check({tag, "_reg3"}, reg3, 16'h0020);
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                       input logic [SW-1:0] ws, input logic ea, input logic [AW-1:0] aa,
                       input logic eb, input logic [AW-1:0] ab);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_strb = ws;
    rd_en_a = ea; rd_addr_a = aa; rd_en_b = eb; rd_addr_b = ab;
  endtask

  // One clock: push expectations, update model, take the edge, pop and compare.
  task automatic step();
    logic ea, eb;
    ea = rd_en_a;
    eb = rd_en_b;
    if (ea) qa.push_back(expect_rd(rd_addr_a));
    if (eb) qb.push_back(expect_rd(rd_addr_b));
    if (wr_en) model[wr_addr] = merge(model[wr_addr], wr_data, wr_strb);
    @(posedge clk);
    #1;
    if (ea) begin
      last_a = qa.pop_front();
      check("rd_a", rd_data_a, last_a);
      check("valid_a_hi", {15'b0, rd_valid_a}, 16'h1);
    end else begin
      check("valid_a_lo", {15'b0, rd_valid_a}, 16'h0);
      check("hold_a", rd_data_a, last_a);
    end
    if (eb) begin
      last_b = qb.pop_front();
      check("rd_b", rd_data_b, last_b);
      check("valid_b_hi", {15'b0, rd_valid_b}, 16'h1);
    end else begin
      check("valid_b_lo", {15'b0, rd_valid_b}, 16'h0);
      check("hold_b", rd_data_b, last_b);
    end
    check("tap0", reg0, model[0]);
    check("tap1", reg1, model[1]);
    check("tap2", reg2, model[2]);
    check("tap3", reg3, model[3]);
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    // Reset asserted with random inputs
    rst = 1'b1;
    drive(1'b1, AW'($urandom), W'($urandom), SW'($urandom), 1'b1, AW'($urandom),
          1'b1, AW'($urandom));
    #2 rst = 1'b0;
    #1 check_reset_outputs("rst0");
    model_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    idle();

    // Reset contents on both ports
    for (int i = 0; i < L; i++) begin
      drive(1'b0, '0, '0, '0, 1'b1, AW'(i), 1'b1, AW'(L - 1 - i));
      step();
    end
    idle();
    step();

    // Fill, then back-to-back burst: A ascending, B descending
    for (int i = 0; i < L; i++) begin
      drive(1'b1, AW'(i), 16'hA500 + 16'(i), 2'b11, 1'b0, '0, 1'b0, '0);
      step();
    end
    for (int i = 0; i < L; i++) begin
      drive(1'b0, '0, '0, '0, 1'b1, AW'(i), 1'b1, AW'(L - 1 - i));
      step();
    end

    // Byte strobes on line 5
    drive(1'b1, 3'd5, 16'h1234, 2'b11, 1'b0, '0, 1'b0, '0); step();
    drive(1'b1, 3'd5, 16'hABCD, 2'b01, 1'b1, 3'd5, 1'b0, '0); step();
    check("strb_lo", model[5], 16'h12CD);
    drive(1'b1, 3'd5, 16'hEF00, 2'b10, 1'b0, '0, 1'b1, 3'd5); step();
    drive(1'b1, 3'd5, 16'hFFFF, 2'b00, 1'b1, 3'd5, 1'b1, 3'd5); step();
    check("strb_none_a", rd_data_a, 16'hEFCD);
    check("strb_none_b", rd_data_b, 16'hEFCD);

    // Write-through on line 3, both ports
    drive(1'b1, 3'd3, 16'h0020, 2'b11, 1'b0, '0, 1'b0, '0); step();
    drive(1'b1, 3'd3, 16'h7788, 2'b01, 1'b1, 3'd3, 1'b1, 3'd3); step();
    check("wt_a", rd_data_a, 16'h0088);
    check("wt_b", rd_data_b, 16'h0088);
    check("wt_reg3", reg3, 16'h0088);

    // Valid falls, data holds
    drive(1'b1, 3'd1, 16'h0042, 2'b11, 1'b0, '0, 1'b0, '0); step();
    drive(1'b0, '0, '0, '0, 1'b1, 3'd1, 1'b0, '0); step();
    idle(); step();
    check("hold_42", rd_data_a, 16'h0042);

    // Async reset midway through a write/read burst
    drive(1'b1, 3'd6, 16'h1111, 2'b11, 1'b1, 3'd4, 1'b1, 3'd7); step();
    drive(1'b1, 3'd6, 16'h2222, 2'b11, 1'b1, 3'd6, 1'b1, 3'd2);
    #4 rst = 1'b0;
    #1 check_reset_outputs("rst_mid");
    drive(1'b1, 3'd0, 16'hFFFF, 2'b11, 1'b1, 3'd0, 1'b1, 3'd1);
    @(posedge clk);
    #1 check_reset_outputs("rst_held");
    model_reset();
    #2 rst = 1'b1;
    idle();
    for (int i = 0; i < L; i++) begin
      drive(1'b0, '0, '0, '0, 1'b1, AW'(i), 1'b1, AW'(L - 1 - i));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
